// File: rtl/mbist_op_seq_if.sv
// mbist_op_seq_if: handshake/bus bundle between an MBIST element controller
// (master) and the march-operation sequencer (slave).
//   master -> slave : start, stimulus, re_init, addr_last, op_ready
//   slave -> master : op_valid, op_read/op_write/op_invert, op_updown,
//                     op_reverse, op_repeatflag, op_index, last_op,
//                     elem_done, busy, cfg_err
interface mbist_op_seq_if #(
   parameter int unsigned BIST_OP_MAX = 8
);
   localparam int unsigned BIST_OP_PTR_WD = $clog2(BIST_OP_MAX);
   localparam int unsigned BIST_OP_CNT_WD = $clog2(BIST_OP_MAX + 1);
   localparam int unsigned BIST_STI_WD    = 3 * BIST_OP_MAX + BIST_OP_CNT_WD + 3;

   logic                      start;
   logic [BIST_STI_WD-1:0]    stimulus;
   logic                      re_init;
   logic                      addr_last;
   logic                      op_ready;
   logic                      op_valid;
   logic                      op_read;
   logic                      op_write;
   logic                      op_invert;
   logic                      op_updown;
   logic                      op_reverse;
   logic                      op_repeatflag;
   logic [BIST_OP_PTR_WD-1:0] op_index;
   logic                      last_op;
   logic                      elem_done;
   logic                      busy;
   logic                      cfg_err;

   modport master (
      output start, stimulus, re_init, addr_last, op_ready,
      input  op_valid, op_read, op_write, op_invert, op_updown, op_reverse,
             op_repeatflag, op_index, last_op, elem_done, busy, cfg_err
   );

   modport slave (
      input  start, stimulus, re_init, addr_last, op_ready,
      output op_valid, op_read, op_write, op_invert, op_updown, op_reverse,
             op_repeatflag, op_index, last_op, elem_done, busy, cfg_err
   );
endinterface

// File: rtl/mbist_op_seq.sv
// mbist_op_seq: march-operation sequencer. Latches a march-element stimulus
// word, walks its active op slots with a binary pointer, presents each op over
// a valid/ready handshake, repeats the list per address until the address
// generator flags the last address, then pulses elem_done.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   scan_shift  : scan shift enable (op pointer is the scan chain)
//   sdi / sdo   : scan data in / out (sdo = op_ptr[0])
//   bus         : mbist_op_seq_if.slave handshake/op bundle
module mbist_op_seq #(
   parameter int unsigned BIST_OP_MAX = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           scan_shift,
   input  logic           sdi,
   output logic           sdo,
   mbist_op_seq_if.slave  bus
);

   localparam int unsigned PTR_WD   = $clog2(BIST_OP_MAX);
   localparam int unsigned CNT_WD   = $clog2(BIST_OP_MAX + 1);
   localparam int unsigned STI_WD   = 3 * BIST_OP_MAX + CNT_WD + 3;
   localparam int unsigned CNT_LSB  = 3 * BIST_OP_MAX;
   localparam int unsigned SLOT_NUM = 1 << PTR_WD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_WD-1:0]   op_ptr_q, op_ptr_d;
   logic [STI_WD-1:0]   sti_q, sti_d;
   logic                cfg_err_q, cfg_err_d;

   logic [CNT_WD-1:0]   op_cnt;
   logic [CNT_WD-1:0]   start_cnt;
   logic                start_legal;
   logic                in_run;
   logic                present;
   logic                is_last;
   logic                fire;
   logic [2:0]          slot [SLOT_NUM];

   // Op slots as an array indexed by the pointer; pointer values beyond the
   // configured slots (reachable only via scan) read as a null op.
   for (genvar g = 0; g < SLOT_NUM; g++) begin : g_slot
      if (g < BIST_OP_MAX) begin : g_used
         assign slot[g] = sti_q[3*g +: 3];
      end else begin : g_unused
         assign slot[g] = 3'b000;
      end
   end

   assign op_cnt      = sti_q[CNT_LSB +: CNT_WD];
   assign start_cnt   = bus.stimulus[CNT_LSB +: CNT_WD];
   assign start_legal = (start_cnt != '0) && (start_cnt <= CNT_WD'(BIST_OP_MAX));

   assign in_run  = (state_q == ST_RUN);
   // re_init and scan both suppress the op in the cycle they are asserted
   assign present = in_run && !scan_shift && !bus.re_init;
   assign is_last = (CNT_WD'(op_ptr_q) == (op_cnt - CNT_WD'(1)));
   assign fire    = present && bus.op_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: op pointer, latched stimulus, sticky config error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_ptr_q  <= '0;
         sti_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         op_ptr_q  <= op_ptr_d;
         sti_q     <= sti_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Next-state and datapath update; scan shift overrides everything
   always_comb begin
      state_d   = state_q;
      op_ptr_d  = op_ptr_q;
      sti_d     = sti_q;
      cfg_err_d = cfg_err_q;

      if (scan_shift) begin
         // {sdi, op_ptr[W-1:1]} written so it also holds for a 1-bit pointer
         op_ptr_d = PTR_WD'({sdi, op_ptr_q} >> 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (start_legal) begin
                     sti_d     = bus.stimulus;
                     cfg_err_d = 1'b0;
                     op_ptr_d  = '0;
                     state_d   = ST_RUN;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.re_init) begin
                  op_ptr_d = '0;
               end else if (fire) begin
                  if (is_last) begin
                     op_ptr_d = '0;
                     if (bus.addr_last) begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     op_ptr_d = op_ptr_q + PTR_WD'(1);
                  end
               end
            end
            ST_DONE: begin
               op_ptr_d = '0;
               state_d  = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.op_valid      = present;
   assign bus.op_write      = in_run && slot[op_ptr_q][2];
   assign bus.op_read       = in_run && slot[op_ptr_q][1];
   assign bus.op_invert     = in_run && slot[op_ptr_q][0];
   assign bus.last_op       = present && is_last;
   assign bus.op_index      = op_ptr_q;
   assign bus.op_updown     = sti_q[STI_WD-1];
   assign bus.op_reverse    = sti_q[STI_WD-2];
   assign bus.op_repeatflag = sti_q[STI_WD-3];
   assign bus.elem_done     = (state_q == ST_DONE) && !scan_shift;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.cfg_err       = cfg_err_q;
   assign sdo               = op_ptr_q[0];

endmodule

// File: tb/tb_mbist_op_seq.sv
// Testbench for mbist_op_seq: directed stimulus with a queue-based scoreboard;
// a negedge monitor checks every op fire and elem_done against the queue.
module tb_mbist_op_seq;

   localparam int unsigned OP_MAX = 8;
   localparam int unsigned CNT_WD = 4;
   localparam int unsigned STI_WD = 3 * OP_MAX + CNT_WD + 3;

   logic clk = 1'b0;
   logic rst_n;
   logic scan_shift;
   logic sdi;
   logic sdo;

   mbist_op_seq_if #(.BIST_OP_MAX(OP_MAX)) bus ();

   mbist_op_seq #(.BIST_OP_MAX(OP_MAX)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_shift (scan_shift),
      .sdi        (sdi),
      .sdo        (sdo),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_done;
      int unsigned idx;
      logic [2:0]  wri;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_op(input int unsigned idx, input logic [2:0] wri, input logic last);
      exp_t e;
      e.is_done = 1'b0;
      e.idx     = idx;
      e.wri     = wri;
      e.last    = last;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1;
      e.idx     = 0;
      e.wri     = 3'b000;
      e.last    = 1'b0;
      exp_q.push_back(e);
   endtask

   function automatic logic [STI_WD-1:0] mk_sti(input logic [2:0] top,
                                                input logic [CNT_WD-1:0] cnt,
                                                input logic [3*OP_MAX-1:0] slots);
      return {top, cnt, slots};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [STI_WD-1:0] s);
      bus.stimulus = s;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (bus.busy && k < budget) begin
         tick();
         k++;
      end
      n_chk++;
      if (bus.busy) begin
         n_fail++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
      end
   endtask

   // Scoreboard monitor: every fire and every elem_done consumes one entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_fire: op_index %0d fired, nothing expected", bus.op_index);
            end else begin
               mon_e = exp_q.pop_front();
               chk("fire_kind_is_op", 32'(mon_e.is_done), 32'(0));
               chk("fire_op_index", 32'(bus.op_index), 32'(mon_e.idx));
               chk("fire_wri", 32'({bus.op_write, bus.op_read, bus.op_invert}), 32'(mon_e.wri));
               chk("fire_last_op", 32'(bus.last_op), 32'(mon_e.last));
            end
         end
         if (bus.elem_done) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_elem_done: elem_done 1, nothing expected");
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_kind", 32'(mon_e.is_done), 32'(1));
               chk("done_op_valid", 32'(bus.op_valid), 32'(0));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [STI_WD-1:0] sti3;
      logic [STI_WD-1:0] sti8;
      sti3 = mk_sti(3'b000, 4'd3, 24'(9'b101_010_100));
      sti8 = mk_sti(3'b000, 4'd8, 24'o76543210);

      rst_n         = 1'b0;
      scan_shift    = 1'b0;
      sdi           = 1'b0;
      bus.start     = 1'b0;
      bus.stimulus  = '0;
      bus.re_init   = 1'b0;
      bus.addr_last = 1'b0;
      bus.op_ready  = 1'b0;
      #1;

      // Reset state
      chk("rst_op_valid", 32'(bus.op_valid), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_elem_done", 32'(bus.elem_done), 32'(0));
      chk("rst_cfg_err", 32'(bus.cfg_err), 32'(0));
      chk("rst_op_index", 32'(bus.op_index), 32'(0));
      chk("rst_sdo", 32'(sdo), 32'(0));
      chk("rst_updown", 32'(bus.op_updown), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Two address passes over three ops
      bus.op_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         push_op(0, 3'b100, 1'b0);
         push_op(1, 3'b010, 1'b0);
         push_op(2, 3'b101, 1'b1);
      end
      push_done();
      do_start(sti3);
      chk("t1_busy", 32'(bus.busy), 32'(1));
      chk("t1_op_index", 32'(bus.op_index), 32'(0));
      tick();
      tick();
      tick();
      bus.addr_last = 1'b1;
      wait_idle(10, "t1_idle");
      bus.addr_last = 1'b0;

      // Backpressure at index 1
      push_op(0, 3'b100, 1'b0);
      push_op(1, 3'b010, 1'b0);
      push_op(2, 3'b101, 1'b1);
      push_done();
      bus.addr_last = 1'b1;
      do_start(sti3);
      tick();
      bus.op_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t2_hold_index", 32'(bus.op_index), 32'(1));
         chk("t2_hold_read", 32'(bus.op_read), 32'(1));
         tick();
      end
      bus.op_ready = 1'b1;
      chk("t2_hold_index", 32'(bus.op_index), 32'(1));
      chk("t2_hold_read", 32'(bus.op_read), 32'(1));
      wait_idle(10, "t2_idle");

      // re_init at index 2
      push_op(0, 3'b100, 1'b0);
      push_op(1, 3'b010, 1'b0);
      push_op(0, 3'b100, 1'b0);
      push_op(1, 3'b010, 1'b0);
      push_op(2, 3'b101, 1'b1);
      push_done();
      do_start(sti3);
      tick();
      tick();
      bus.re_init = 1'b1;
      #1;
      chk("t3_reinit_index", 32'(bus.op_index), 32'(2));
      chk("t3_reinit_valid", 32'(bus.op_valid), 32'(0));
      chk("t3_reinit_last", 32'(bus.last_op), 32'(0));
      chk("t3_reinit_done", 32'(bus.elem_done), 32'(0));
      tick();
      bus.re_init = 1'b0;
      #1;
      chk("t3_resume_index", 32'(bus.op_index), 32'(0));
      chk("t3_resume_valid", 32'(bus.op_valid), 32'(1));
      wait_idle(10, "t3_idle");
      bus.addr_last = 1'b0;

      // Illegal op counts, then a legal start
      bus.op_ready = 1'b0;
      do_start(mk_sti(3'b000, 4'd0, 24'(9'b101_010_100)));
      chk("t4_cnt0_busy", 32'(bus.busy), 32'(0));
      chk("t4_cnt0_cfg_err", 32'(bus.cfg_err), 32'(1));
      do_start(mk_sti(3'b000, 4'd9, 24'(9'b101_010_100)));
      chk("t4_cnt9_busy", 32'(bus.busy), 32'(0));
      chk("t4_cnt9_cfg_err", 32'(bus.cfg_err), 32'(1));
      do_start(sti3);
      chk("t4_legal_cfg_err", 32'(bus.cfg_err), 32'(0));
      chk("t4_legal_busy", 32'(bus.busy), 32'(1));
      chk("t4_legal_valid", 32'(bus.op_valid), 32'(1));
      push_op(0, 3'b100, 1'b0);
      push_op(1, 3'b010, 1'b0);
      push_op(2, 3'b101, 1'b1);
      push_done();
      bus.addr_last = 1'b1;
      bus.op_ready  = 1'b1;
      wait_idle(10, "t4_idle");
      bus.addr_last = 1'b0;

      // Scan through the op pointer while running at index 1
      push_op(0, 3'b100, 1'b0);
      do_start(sti3);
      tick();
      scan_shift = 1'b1;
      sdi        = 1'b1;
      #1;
      chk("t5_sdo0", 32'(sdo), 32'(1));
      chk("t5_shift_valid", 32'(bus.op_valid), 32'(0));
      tick();
      sdi = 1'b0;
      #1;
      chk("t5_sdo1", 32'(sdo), 32'(0));
      chk("t5_shift_valid", 32'(bus.op_valid), 32'(0));
      tick();
      sdi = 1'b1;
      #1;
      chk("t5_sdo2", 32'(sdo), 32'(0));
      chk("t5_shift_valid", 32'(bus.op_valid), 32'(0));
      tick();
      scan_shift = 1'b0;
      sdi        = 1'b0;
      #1;
      chk("t5_post_index", 32'(bus.op_index), 32'(5));
      chk("t5_post_busy", 32'(bus.busy), 32'(1));
      chk("t5_post_valid", 32'(bus.op_valid), 32'(1));
      chk("t5_post_last", 32'(bus.last_op), 32'(0));
      push_op(5, 3'b000, 1'b0);
      push_op(6, 3'b000, 1'b0);
      push_op(7, 3'b000, 1'b0);
      push_op(0, 3'b100, 1'b0);
      push_op(1, 3'b010, 1'b0);
      push_op(2, 3'b101, 1'b1);
      push_done();
      bus.addr_last = 1'b1;
      wait_idle(20, "t5_idle");
      bus.addr_last = 1'b0;

      // Asynchronous reset mid-element at index 4, then a fresh element
      for (int i = 0; i < 4; i++) push_op(i, 3'(i), 1'b0);
      do_start(sti8);
      tick();
      tick();
      tick();
      tick();
      chk("t6_pre_index", 32'(bus.op_index), 32'(4));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(bus.op_valid), 32'(0));
      chk("t6_rst_busy", 32'(bus.busy), 32'(0));
      chk("t6_rst_index", 32'(bus.op_index), 32'(0));
      chk("t6_rst_last", 32'(bus.last_op), 32'(0));
      chk("t6_rst_done", 32'(bus.elem_done), 32'(0));
      chk("t6_rst_wri", 32'({bus.op_write, bus.op_read, bus.op_invert}), 32'(0));
      chk("t6_rst_sdo", 32'(sdo), 32'(0));
      chk("t6_queue_drained", 32'(exp_q.size()), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) push_op(i, 3'(i), (i == 7));
      push_done();
      bus.addr_last = 1'b1;
      do_start(mk_sti(3'b101, 4'd8, 24'o76543210));
      chk("t6_restart_index", 32'(bus.op_index), 32'(0));
      chk("t6_updown", 32'(bus.op_updown), 32'(1));
      chk("t6_reverse", 32'(bus.op_reverse), 32'(0));
      chk("t6_repeat", 32'(bus.op_repeatflag), 32'(1));
      wait_idle(20, "t6_idle");
      bus.addr_last = 1'b0;
      tick();

      chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mbist_op_seq.md
Name: mbist_op_seq

Overview:
Parametrised march-operation sequencer for the MBIST controller. It is the next generation of the one-hot operation selector.
- Latches a march-element stimulus word holding up to OP_MAX {write,read,invert} op slots plus a programmable active-op count.
- Steps through the active ops with a binary pointer and presents each op to the address generator / memory interface over a valid/ready handshake.
- Repeats the op list for every address until the address generator flags the last address, then reports element completion.
- Supports re-init (error-repair rewind) and a scan chain through the op pointer.

Parameters:
- BIST_OP_MAX, 8, maximum ops per march element (2..16).
- BIST_OP_PTR_WD, $clog2(BIST_OP_MAX), width of the op pointer and of op_index.
- BIST_OP_CNT_WD, $clog2(BIST_OP_MAX+1), width of the active-op-count field.
- BIST_STI_WD, 3*BIST_OP_MAX+BIST_OP_CNT_WD+3, stimulus width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- scan_shift  in  1  scan shift enable
- sdi  in  1  scan data in
- sdo  out  1  scan data out (op_ptr[0])
- start  in  1  one-cycle pulse: latch stimulus and begin the element
- stimulus  in  BIST_STI_WD  [3i+2:3i]={write,read,invert} of op i; then op_cnt field; top 3 bits={updown,reverse,repeatflag}
- re_init  in  1  rewind to op 0 after error correction
- addr_last  in  1  address generator is on the final address
- op_ready  in  1  downstream accepts the current op
- op_valid  out  1  op outputs are valid
- op_read, op_write, op_invert  out  1 each  fields of the current op
- op_updown, op_reverse, op_repeatflag  out  1 each  element-level fields (from latched stimulus)
- op_index  out  BIST_OP_PTR_WD  current op pointer
- last_op  out  1  current op is the last active op
- elem_done  out  1  one-cycle pulse when the element completes
- busy  out  1  FSM not in IDLE
- cfg_err  out  1  illegal op_cnt at start (sticky until the next start)

Behaviour:
- Reset: FSM=IDLE, op_ptr=0, latched stimulus=0. All outputs are 0 (sdo=0).
- Storage: stimulus is captured into sti_q on an accepted start. All op and element outputs derive from sti_q, never from the live input.
- FSM states:
  - IDLE → RUN on start with 1<=op_cnt<=BIST_OP_MAX; op_ptr cleared to 0.
  - IDLE stays IDLE on start with op_cnt==0 or op_cnt>BIST_OP_MAX; cfg_err set.
  - RUN: op_valid=1; op_read/op_write/op_invert = slot op_ptr of sti_q; last_op = (op_ptr==op_cnt-1).
  - Handshake fire = op_valid & op_ready.
    - Fire and not last_op: op_ptr+1.
    - Fire and last_op and !addr_last: op_ptr wraps to 0, FSM stays in RUN.
    - Fire and last_op and addr_last: FSM → DONE.
    - No fire: all outputs held stable (no change while op_ready=0).
  - DONE: elem_done=1 and op_valid=0 for exactly one cycle; op_ptr cleared; FSM → IDLE.
- start while busy is ignored. start and scan_shift in the same cycle: scan_shift wins and start is dropped.
- re_init in RUN:
  - op_ptr=0 next cycle; op_valid and last_op forced to 0 in the re_init cycle.
  - Any fire in that cycle is discarded; no advance, no DONE.
  - The sequence resumes at op 0 in the following cycle.
  - re_init has no effect in IDLE or DONE.
- scan_shift (highest priority, any state):
  - op_ptr <= {sdi, op_ptr[BIST_OP_PTR_WD-1:1]}; sdo=op_ptr[0].
  - FSM state frozen; op_valid and elem_done forced to 0.
  - A pointer shifted in beyond op_cnt-1 is not corrected. last_op stays 0 until the pointer wraps through BIST_OP_PTR_WD rollover, which is legal and documented.
- busy = (state!=IDLE). cfg_err clears on the next legal start.
- op_cnt==BIST_OP_MAX: the pointer reaches BIST_OP_MAX-1 and then wraps to 0. Unused slots (index>=op_cnt) are never presented.
- Asynchronous reset mid-element aborts immediately to IDLE; no elem_done.

Test Plan:
- op_cnt=3, slots {w=1,i=0},{r=1,i=0},{w=1,i=1}, op_ready=1, addr_last high on the 2nd pass → op_index 0,1,2,0,1,2; last_op on index 2; elem_done one cycle after the 6th fire; busy low after.
- Same stimulus, op_ready low for 4 cycles at index 1 → op_index/op_read stay 1/1 for 5 cycles; no skipped ops.
- re_init asserted while op_index=2 with op_ready=1 → that cycle op_valid=0, last_op=0, no elem_done; next cycle op_index=0, op_valid=1.
- start with op_cnt=0, then with op_cnt=9 (BIST_OP_MAX=8) → busy stays 0, cfg_err=1; then a legal start → cfg_err=0, busy=1.
- In RUN at index 1, scan_shift for 3 cycles with sdi=1,0,1 → sdo sequence 1,0,0, op_ptr=3'b101, op_valid=0 during shift; FSM is still RUN after shift with op_index=5.
- rst_n low mid-element at index 4 (op_cnt=8) → all outputs 0 immediately; the next start begins at op_index 0.
